// File: rtl/wall_slice_scaler_pkg.sv
// Shared fixed-point parameters, FSM encoding and slice record for the wall slice scaler.
package wall_slice_scaler_pkg;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned HALF_W = 320;
    localparam int unsigned HK     = 8;
    localparam int unsigned UF     = 12;

    localparam int unsigned VD_W   = 16;   // vdist, UQ7.9
    localparam int unsigned UACC_W = 18;   // u accumulator, [5:-UF]
    localparam int unsigned DIV_W  = 18;
    localparam int unsigned HV_W   = 9;
    localparam int unsigned HPOS_W = 10;

    localparam logic [DIV_W-1:0]  DIVIDEND = DIV_W'(1 << (HK + 9));
    localparam logic [UACC_W-1:0] U0_FULL  = UACC_W'(32 << UF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_FIN,
        ST_READY
    } state_t;

    typedef struct packed {
        logic [HV_W-1:0]   h;
        logic [UACC_W-1:0] u0;
        logic [VD_W-1:0]   step;
        logic              side;
        logic [5:0]        tex;
    } slice_t;

    // HALF_W * v as 256v + 64v, kept modulo 2^UACC_W
    function automatic logic [UACC_W-1:0] halfWTimes(input logic [VD_W-1:0] v);
        logic [UACC_W-1:0] w;
        w = UACC_W'(v);
        return (w << 8) + (w << 6);
    endfunction

endpackage

// File: rtl/wall_slice_scaler_seq_divider.sv
// Restoring divider, one quotient bit per cycle, with start/busy/done handshake.
module seq_divider
    import wall_slice_scaler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dvd;
    logic [4:0]       cnt;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   diff;
    logic             fits;

    always_comb begin
        shifted = {rem, dvd[DIV_W-1]};
        fits    = shifted >= {1'b0, divisor};
        diff    = shifted - {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                dvd      <= dividend;
                quotient <= '0;
                cnt      <= 5'(DIV_W);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
                dvd      <= {dvd[DIV_W-2:0], 1'b0};
                quotient <= {quotient[DIV_W-2:0], fits};
                cnt      <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wall_slice_scaler.sv
// Converts the tracer's per-line distance into a double-buffered wall slice
// and walks the texture u coordinate along the scanline.
module wall_slice_scaler
    import wall_slice_scaler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hmax,
    input  logic [HPOS_W-1:0] hpos,
    input  logic [VD_W-1:0]   i_vdist,
    input  logic              i_side,
    input  logic [5:0]        i_tex,
    output logic              o_wall,
    output logic              o_side,
    output logic [5:0]        o_tex_u,
    output logic [5:0]        o_tex_v,
    output logic              o_late
);

    state_t           state, stateNext;
    slice_t           shadow, active;
    logic             shadowZero;
    logic             divStart, divBusy, divDone;
    logic [DIV_W-1:0] divQuot;
    logic             finSat;
    logic [HV_W-1:0]  finH;
    logic [UACC_W-1:0] finU0;
    logic             inFlight;

    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (divStart),
        .dividend (DIVIDEND),
        .divisor  (DIV_W'(i_vdist)),
        .busy     (divBusy),
        .done     (divDone),
        .quotient (divQuot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    // The state entered on hmax is the cycle the tracer result is valid, so LOAD samples it directly.
    always_comb begin
        stateNext = state;
        divStart  = 1'b0;
        case (state)
            ST_IDLE, ST_READY: stateNext = state;
            ST_LOAD: begin
                if (i_vdist == '0) begin
                    stateNext = ST_FIN;
                end else begin
                    stateNext = ST_DIV;
                    divStart  = 1'b1;
                end
            end
            ST_DIV:  if (divDone && !divBusy) stateNext = ST_FIN;
            ST_FIN:  stateNext = ST_READY;
            default: stateNext = ST_IDLE;
        endcase
        if (hmax) stateNext = ST_LOAD;
    end

    always_comb begin
        inFlight = (state == ST_LOAD) || (state == ST_DIV) || (state == ST_FIN);
        finSat   = shadowZero || (divQuot >= DIV_W'(HALF_W));
        finH     = finSat ? HV_W'(HALF_W) : divQuot[HV_W-1:0];
        finU0    = finSat ? (U0_FULL - halfWTimes(shadow.step)) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            active     <= '0;
            shadowZero <= 1'b0;
            o_late     <= 1'b0;
        end else begin
            if (state == ST_LOAD) begin
                shadow.step <= i_vdist;
                shadow.side <= i_side;
                shadow.tex  <= i_tex;
                shadowZero  <= (i_vdist == '0);
            end
            if (state == ST_FIN) begin
                shadow.h  <= finH;
                shadow.u0 <= finU0;
            end
            if (hmax) begin
                if (inFlight) begin
                    active <= '{h: HV_W'(HALF_W), u0: '0, step: '0,
                                side: shadow.side, tex: shadow.tex};
                    o_late <= 1'b1;
                end else begin
                    active <= shadow;
                end
            end
        end
    end

    logic [HPOS_W-1:0] spanLo, spanHi;
    logic              inWall;
    logic [UACC_W-1:0] uAcc, uCur, uNext;
    logic [UACC_W:0]   uSum;

    always_comb begin
        spanLo = HPOS_W'(HALF_W) - HPOS_W'(active.h);
        spanHi = HPOS_W'(HALF_W) + HPOS_W'(active.h);
        inWall = (hpos >= spanLo) && (hpos < spanHi) && (hpos < HPOS_W'(H_VIS));
        uCur   = (hpos == spanLo) ? active.u0 : uAcc;
        uSum   = (UACC_W+1)'(uCur) + (UACC_W+1)'(active.step);
        uNext  = uSum[UACC_W] ? '1 : uSum[UACC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_wall  <= 1'b0;
            o_side  <= 1'b0;
            o_tex_u <= '0;
            o_tex_v <= '0;
            uAcc    <= '0;
        end else if (inWall) begin
            o_wall  <= 1'b1;
            o_side  <= active.side;
            o_tex_u <= uCur[UACC_W-1:UF];
            o_tex_v <= active.tex;
            uAcc    <= uNext;
        end else begin
            o_wall  <= 1'b0;
            o_tex_u <= '0;
            o_tex_v <= '0;
        end
    end

endmodule
